addsub_pipe: RTL and testbench

Parametrised, pipelined add/subtract unit for the DCPU-16 ALU. It is the generalised successor of the 16-bit adder.
- Supports ADD, SUB, ADX and SBX, with DCPU-16 EX-register semantics.
- Configurable datapath width and pipeline depth.
- valid/ready handshake on both sides.
- Sits between the operand-fetch stage and the writeback of b/EX.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/addsub_seg.sv | 20 ++
 rtl/addsub_pipe.sv | 153 +++++++++++++++
 tb/tb_addsub_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared DCPU-16 ALU definitions: add/sub opcodes, EX constants and segment sizing.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ADX = 2'd2,
    OP_SBX = 2'd3
  } addsub_op_e;

  // Widest datapath the EX constant helper can size for.
  localparam int MAX_WIDTH = 64;

  function automatic logic [MAX_WIDTH-1:0] ex_const(input int width, input bit underflow);
    logic [MAX_WIDTH-1:0] mask;
    mask = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
    return underflow ? mask : MAX_WIDTH'(1);
  endfunction

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// One combinational carry-chain segment: three operand digits plus a 2-bit carry.
module addsub_seg #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic [SW-1:0] ex,
  input  logic [1:0]    cin,
  output logic [SW-1:0] sum,
  output logic [1:0]    cout
);

  logic [SW+1:0] total;

  // Worst-case digit sum is 3*(2^SW-1)+2, so two carry bits always suffice.
  assign total = {2'b00, a} + {2'b00, b} + {2'b00, ex} + {{SW{1'b0}}, cin};
  assign sum   = total[SW-1:0];
  assign cout  = total[SW+1:SW];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined DCPU-16 ADD/SUB/ADX/SBX unit with EX semantics and valid/ready flow control.
// Optional saturation of q is enabled by defining ADDSUB_SAT_EN (adds the sat port).
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  addsub_op_e       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] ex_in,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] ex_out,
  output logic             cout,
  output logic             of
);

  localparam int SW   = seg_width(WIDTH, STAGES);
  localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;
  localparam logic [MAX_WIDTH-1:0] EX_UNF_FULL = ex_const(WIDTH, 1'b1);
  localparam logic [MAX_WIDTH-1:0] EX_OVF_FULL = ex_const(WIDTH, 1'b0);
  localparam logic [WIDTH-1:0] EX_UNF = EX_UNF_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] EX_OVF = EX_OVF_FULL[WIDTH-1:0];

  // b is stored already inverted for SUB/SBX; ex is stored zeroed for ADD/SUB.
  typedef struct packed {
    logic             valid;
    logic             sub;
    logic             extended;
    logic             sat;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] ex;
    logic [WIDTH-1:0] sum;
    logic [1:0]       carry;
  } stage_t;

  logic   advance;
  stage_t prep;
  stage_t fin;
  stage_t st [NREG];

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  always_comb begin
    prep          = '0;
    prep.valid    = in_valid;
    prep.sub      = (op == OP_SUB) || (op == OP_SBX);
    prep.extended = (op == OP_ADX) || (op == OP_SBX);
    prep.a        = a;
    prep.b        = prep.sub ? ~b : b;
    prep.ex       = prep.extended ? ex_in : '0;
    prep.carry    = {1'b0, prep.sub};
`ifdef ADDSUB_SAT_EN
    prep.sat      = sat;
`endif
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t        src;
    stage_t        nxt;
    logic [SW-1:0] seg_sum;
    logic [1:0]    seg_carry;

    if (k == 0) begin : g_first
      assign src = prep;
    end else begin : g_mid
      assign src = st[k-1];
    end

    addsub_seg #(.SW(SW)) u_seg (
      .a    (src.a[k*SW +: SW]),
      .b    (src.b[k*SW +: SW]),
      .ex   (src.ex[k*SW +: SW]),
      .cin  (src.carry),
      .sum  (seg_sum),
      .cout (seg_carry)
    );

    always_comb begin
      nxt                   = src;
      nxt.sum[k*SW +: SW]   = seg_sum;
      nxt.carry             = seg_carry;
    end

    if (k < STAGES - 1) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          st[k] <= '0;
        end else if (advance) begin
          st[k] <= nxt;
        end
      end
    end else begin : g_last
      assign fin = nxt;
    end
  end

  // Final carry is R's top two bits; subtraction carries an implicit -2^WIDTH.
  logic             under;
  logic             over;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] ex_n;
  logic             of_n;

  assign under = fin.sub && (fin.carry == 2'd0);
  assign over  = fin.sub ? (fin.carry == 2'd2) : (fin.carry != 2'd0);

  always_comb begin
    q_n = fin.sum;
    if (fin.sat && over) begin
      q_n = '1;
    end else if (fin.sat && under) begin
      q_n = '0;
    end
    ex_n = '0;
    if (under) begin
      ex_n = EX_UNF;
    end else if (over) begin
      ex_n = EX_OVF;
    end
    of_n = !fin.extended && (fin.a[WIDTH-1] == fin.b[WIDTH-1]) &&
           (fin.sum[WIDTH-1] != fin.a[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      q         <= '0;
      ex_out    <= '0;
      cout      <= 1'b0;
      of        <= 1'b0;
    end else if (advance) begin
      out_valid <= fin.valid;
      q         <= q_n;
      ex_out    <= ex_n;
      cout      <= over;
      of        <= of_n;
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed self-checking bench for addsub_pipe at STAGES = 2, 1, 4 and 16 (WIDTH = 16).
module tb_addsub_pipe;
  import alu_pkg::*;

  function automatic int stages_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  typedef struct {
    addsub_op_e  o;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ex;
    logic [15:0] q;
    logic [15:0] eex;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  addsub_op_e  op;
  logic [15:0] a, b, ex_in;
  logic        sat;
  logic        in_valid_v  [4];
  logic        out_ready_v [4];
  logic        in_ready_v  [4];
  logic        out_valid_v [4];
  logic [15:0] q_v         [4];
  logic [15:0] ex_out_v    [4];
  logic        cout_v      [4];
  logic        of_v        [4];

  int   n_checks;
  int   n_fail;
  vec_t stream [6];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    addsub_pipe #(.WIDTH(16), .STAGES(stages_of(i))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[i]),
      .in_ready  (in_ready_v[i]),
      .op        (op),
      .a         (a),
      .b         (b),
      .ex_in     (ex_in),
`ifdef ADDSUB_SAT_EN
      .sat       (sat),
`endif
      .out_valid (out_valid_v[i]),
      .out_ready (out_ready_v[i]),
      .q         (q_v[i]),
      .ex_out    (ex_out_v[i]),
      .cout      (cout_v[i]),
      .of        (of_v[i])
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input addsub_op_e o, input logic [15:0] av,
                               input logic [15:0] bv, input logic [15:0] ev, input logic s);
    op = o;
    a = av;
    b = bv;
    ex_in = ev;
    sat = s;
    in_valid_v[idx] = 1'b1;
    @(negedge clk);
    checkOutput("in_ready", 32'(in_ready_v[idx]), 32'd1);
    @(posedge clk);
    #1;
    in_valid_v[idx] = 1'b0;
  endtask

  task automatic runVector(input string tag, input int idx, input addsub_op_e o,
                           input logic [15:0] av, input logic [15:0] bv, input logic [15:0] ev,
                           input logic s, input logic [15:0] eq, input logic [15:0] eex,
                           input logic ec, input logic eo);
    int lat;
    applyStimulus(idx, o, av, bv, ev, s);
    lat = 1;
    @(negedge clk);
    while (!out_valid_v[idx] && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'(stages_of(idx)));
    checkOutput({tag, ".q"}, 32'(q_v[idx]), 32'(eq));
    checkOutput({tag, ".ex_out"}, 32'(ex_out_v[idx]), 32'(eex));
    checkOutput({tag, ".cout"}, 32'(cout_v[idx]), 32'(ec));
    checkOutput({tag, ".of"}, 32'(of_v[idx]), 32'(eo));
    @(posedge clk);
    #1;
  endtask

  // Six back-to-back ops; out_ready drops for three cycles after the second result.
  task automatic streamTest(input int idx);
    int   sent = 0;
    int   got = 0;
    int   cyc = 0;
    int   stall_left = 0;
    int   extra = 0;
    bit   stall_started = 0;
    logic fire_in;
    logic fire_out;
    while (got < 6 && cyc < 300) begin
      if (sent < 6) begin
        op = stream[sent].o;
        a = stream[sent].a;
        b = stream[sent].b;
        ex_in = stream[sent].ex;
        in_valid_v[idx] = 1'b1;
      end else begin
        in_valid_v[idx] = 1'b0;
      end
      out_ready_v[idx] = (stall_left == 0);
      @(negedge clk);
      checkOutput("bp.in_ready", 32'(in_ready_v[idx]),
                  32'(!(out_valid_v[idx] && !out_ready_v[idx])));
      fire_in  = in_valid_v[idx] && in_ready_v[idx];
      fire_out = out_valid_v[idx] && out_ready_v[idx];
      if (out_valid_v[idx]) begin
        checkOutput("bp.q", 32'(q_v[idx]), 32'(stream[got].q));
        checkOutput("bp.ex_out", 32'(ex_out_v[idx]), 32'(stream[got].eex));
      end
      if (fire_out) got++;
      if (!stall_started && got == 2) begin
        stall_started = 1;
        stall_left = 3;
      end else if (stall_left > 0) begin
        stall_left--;
      end
      @(posedge clk);
      #1;
      if (fire_in) sent++;
      cyc++;
    end
    checkOutput("bp.count", 32'(got), 32'd6);
    in_valid_v[idx] = 1'b0;
    out_ready_v[idx] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid_v[idx]) extra++;
    end
    checkOutput("bp.extra", 32'(extra), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic resetTest();
    int stray = 0;
    op = OP_ADD;
    a = 16'h0001;
    b = 16'h0001;
    ex_in = 16'h0000;
    in_valid_v[2] = 1'b1;
    @(posedge clk);
    #1;
    a = 16'h0002;
    @(posedge clk);
    #1;
    in_valid_v[2] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst.out_valid", 32'(out_valid_v[2]), 32'd0);
    checkOutput("rst.q", 32'(q_v[2]), 32'd0);
    checkOutput("rst.in_ready", 32'(in_ready_v[2]), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid_v[2]) stray++;
    end
    checkOutput("rst.stray", 32'(stray), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    stream[0] = '{OP_ADD, 16'h0001, 16'h0002, 16'h0000, 16'h0003, 16'h0000};
    stream[1] = '{OP_SUB, 16'h0010, 16'h0001, 16'h0000, 16'h000F, 16'h0000};
    stream[2] = '{OP_ADD, 16'h1234, 16'h1111, 16'h0000, 16'h2345, 16'h0000};
    stream[3] = '{OP_SUB, 16'h0003, 16'h0005, 16'h0000, 16'hFFFE, 16'hFFFF};
    stream[4] = '{OP_ADD, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0001};
    stream[5] = '{OP_ADX, 16'h0001, 16'h0001, 16'h0001, 16'h0003, 16'h0000};
    rst = 1'b1;
    op = OP_ADD;
    a = '0;
    b = '0;
    ex_in = '0;
    sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid_v[i] = 1'b0;
      out_ready_v[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checkOutput("reset.out_valid", 32'(out_valid_v[i]), 32'd0);
      checkOutput("reset.q", 32'(q_v[i]), 32'd0);
      checkOutput("reset.ex_out", 32'(ex_out_v[i]), 32'd0);
      checkOutput("reset.cout", 32'(cout_v[i]), 32'd0);
      checkOutput("reset.of", 32'(of_v[i]), 32'd0);
      checkOutput("reset.in_ready", 32'(in_ready_v[i]), 32'd1);
    end
    @(posedge clk);
    #1;

    runVector("add_carry", 0, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0);
    runVector("add_ovf",   0, OP_ADD, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1);
    runVector("add_zero",  0, OP_ADD, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    runVector("sub_borrow",0, OP_SUB, 16'h0000, 16'h0001, 16'h0000, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    runVector("sub_ovf",   0, OP_SUB, 16'h8000, 16'h0001, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 1'b0, 1'b1);
    runVector("sub_equal", 0, OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    runVector("adx_max",   0, OP_ADX, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFD, 16'h0001, 1'b1, 1'b0);
    runVector("sbx_neg",   0, OP_SBX, 16'h0001, 16'h0003, 16'h0001, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    runVector("sbx_carry", 0, OP_SBX, 16'hFFFF, 16'h0000, 16'h0002, 1'b0, 16'h0001, 16'h0001, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      runVector("cfg_add", i, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0);
      runVector("cfg_sbx", i, OP_SBX, 16'h0001, 16'h0003, 16'h0001, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    end
`ifdef ADDSUB_SAT_EN
    runVector("sat_add", 0, OP_ADD, 16'hFFF0, 16'h0020, 16'h0000, 1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
    runVector("sat_sub", 0, OP_SUB, 16'h0001, 16'h0002, 16'h0000, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    runVector("wrap_add", 0, OP_ADD, 16'hFFF0, 16'h0020, 16'h0000, 1'b0, 16'h0010, 16'h0001, 1'b1, 1'b0);
    runVector("wrap_sub", 0, OP_SUB, 16'h0001, 16'h0002, 16'h0000, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 4; i++) begin
      streamTest(i);
    end
    resetTest();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
